// File: rtl/param_register_file_if.sv
// Bus bundle for param_register_file.
//   master: control unit / ALU side, drives writes, inc/dec, RAM data, IR load, read select
//   slave : the register file, returns the mux read, AC, IR and per-register wrap pulses
// NREG must equal 4 + NUM_IDX + NUM_GP of the attached register file.
interface param_register_file_if #(
  parameter int DATA_W = 16,
  parameter int NREG   = 10,
  parameter int OPC_W  = 6
);
  localparam int SEL_W = $clog2(NREG);

  logic [DATA_W-1:0] c_bus_in;
  logic [NREG-1:0]   we;
  logic [NREG-1:0]   inc;
  logic [NREG-1:0]   dec;
  logic [DATA_W-1:0] ram_out;
  logic              dr_read;
  logic              ld_ir;
  logic [SEL_W-1:0]  select;
  logic [DATA_W-1:0] mux_out;
  logic [DATA_W-1:0] ac_out;
  logic [OPC_W-1:0]  ir_out;
  logic [NREG-1:0]   wrap;

  modport master (
    output c_bus_in, we, inc, dec, ram_out, dr_read, ld_ir, select,
    input  mux_out, ac_out, ir_out, wrap
  );

  modport slave (
    input  c_bus_in, we, inc, dec, ram_out, dr_read, ld_ir, select,
    output mux_out, ac_out, ir_out, wrap
  );
endinterface

// File: rtl/param_register_file.sv
// Parametrised processor register file: AR, DR, PC, AC, NUM_IDX index registers
// (inc/dec), NUM_GP general registers, plus the instruction register.
// Index map: 0 AR, 1 DR, 2 PC, 3 AC, 4..3+NUM_IDX index, rest general.
// Ports:
//   clk   - single clock, all state changes on the rising edge
//   rst_n - synchronous active-low reset
//   bus   - param_register_file_if.slave: C-bus write, inc/dec, RAM load into DR,
//           IR load, combinational read mux, AC out, IR out, registered wrap pulses

// One register: load beats inc/dec; inc and dec together cancel.
// inc/dec arrive already masked by what the register supports.
module prf_reg_cell #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_val,
  input  logic              inc,
  input  logic              dec,
  output logic [DATA_W-1:0] val,
  output logic              wrap
);
  logic [DATA_W-1:0] val_q, val_d;
  logic              wrap_q, wrap_d;

  always_comb begin
    val_d  = val_q;
    wrap_d = 1'b0;
    if (load) begin
      val_d = load_val;
    end else if (inc && !dec) begin
      val_d  = val_q + DATA_W'(1);
      wrap_d = &val_q;
    end else if (dec && !inc) begin
      val_d  = val_q - DATA_W'(1);
      wrap_d = ~|val_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      val_q  <= val_d;
      wrap_q <= wrap_d;
    end
  end

  assign val  = val_q;
  assign wrap = wrap_q;
endmodule

module param_register_file #(
  parameter int DATA_W  = 16,
  parameter int NUM_IDX = 3,
  parameter int NUM_GP  = 3,
  parameter int OPC_W   = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  param_register_file_if.slave  bus
);
  localparam int NREG  = 4 + NUM_IDX + NUM_GP;
  localparam int SEL_W = $clog2(NREG);

  logic [NREG-1:0][DATA_W-1:0] regs;
  logic [NREG-1:0]             wrap_w;
  logic [OPC_W-1:0]            ir_q, ir_d;
  logic [SEL_W-1:0]            sel;
  logic [DATA_W-1:0]           mux;

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    // PC only counts up; AC and index registers count both ways.
    localparam bit INC_OK = (i == 2) || (i == 3) || (i >= 4 && i < 4 + NUM_IDX);
    localparam bit DEC_OK = (i == 3) || (i >= 4 && i < 4 + NUM_IDX);

    logic              load;
    logic [DATA_W-1:0] load_val;

    if (i == 1) begin : g_dr
      // C-bus write wins over the RAM load; ram_out is dropped.
      assign load     = bus.we[i] | bus.dr_read;
      assign load_val = bus.we[i] ? bus.c_bus_in : bus.ram_out;
    end else begin : g_plain
      assign load     = bus.we[i];
      assign load_val = bus.c_bus_in;
    end

    prf_reg_cell #(.DATA_W(DATA_W)) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (load_val),
      .inc      (bus.inc[i] & INC_OK),
      .dec      (bus.dec[i] & DEC_OK),
      .val      (regs[i]),
      .wrap     (wrap_w[i])
    );
  end

  // IR takes DR as it was before the edge, so a same-cycle DR load lands next ld_ir.
  always_comb begin
    ir_d = ir_q;
    if (bus.ld_ir) ir_d = regs[1][OPC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ir_q <= '0;
    else        ir_q <= ir_d;
  end

  assign sel = bus.select;

  // Out-of-range selects read zero.
  always_comb begin
    mux = '0;
    if (int'(sel) < NREG) mux = regs[sel];
  end

  assign bus.mux_out = mux;
  assign bus.ac_out  = regs[3];
  assign bus.ir_out  = ir_q;
  assign bus.wrap    = wrap_w;
endmodule

// File: tb/tb_param_register_file.sv
module tb_param_register_file;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n;

  param_register_file_if #(.DATA_W(16), .NREG(10), .OPC_W(6)) ifa ();
  param_register_file_if #(.DATA_W(8),  .NREG(10), .OPC_W(6)) ifb ();

  param_register_file #(.DATA_W(16), .NUM_IDX(3), .NUM_GP(3), .OPC_W(6)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .bus(ifa)
  );
  param_register_file #(.DATA_W(8), .NUM_IDX(1), .NUM_GP(5), .OPC_W(6)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .bus(ifb)
  );

  typedef struct {
    bit          rst;
    logic [15:0] c;
    logic [15:0] ram;
    logic [9:0]  we, inc, dec;
    bit          dr_read, ld_ir;
    int          sel;
  } stim_t;

  typedef struct {
    int          cfg;
    logic [15:0] mux, ac, ir;
    logic [9:0]  wrap;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Reference model: plain register values per configuration.
  int          dw[2]   = '{16, 8};
  int          nidx[2] = '{3, 1};
  logic [15:0] m_reg[2][10];
  logic [15:0] m_ir[2];

  function automatic stim_t idle(int sel);
    stim_t s;
    s.rst = 0; s.c = '0; s.ram = '0; s.we = '0; s.inc = '0; s.dec = '0;
    s.dr_read = 0; s.ld_ir = 0; s.sel = sel;
    return s;
  endfunction

  function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic drive_idle();
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    ifa.c_bus_in = '0; ifa.we = '0; ifa.inc = '0; ifa.dec = '0;
    ifa.ram_out = '0; ifa.dr_read = 0; ifa.ld_ir = 0; ifa.select = '0;
    ifb.c_bus_in = '0; ifb.we = '0; ifb.inc = '0; ifb.dec = '0;
    ifb.ram_out = '0; ifb.dr_read = 0; ifb.ld_ir = 0; ifb.select = '0;
  endtask

  // Drive one cycle of stimulus and push the expected post-edge outputs.
  task automatic step(input int cfg, input stim_t s, input string tag);
    exp_t        e;
    logic [15:0] nxt[10];
    logic [9:0]  wr;
    int          mask;
    @(negedge clk);
    drive_idle();
    if (cfg == 0) begin
      rst_a_n = !s.rst;
      ifa.c_bus_in = s.c; ifa.we = s.we; ifa.inc = s.inc; ifa.dec = s.dec;
      ifa.ram_out = s.ram; ifa.dr_read = s.dr_read; ifa.ld_ir = s.ld_ir;
      ifa.select = 4'(s.sel);
    end else begin
      rst_b_n = !s.rst;
      ifb.c_bus_in = s.c[7:0]; ifb.we = s.we; ifb.inc = s.inc; ifb.dec = s.dec;
      ifb.ram_out = s.ram[7:0]; ifb.dr_read = s.dr_read; ifb.ld_ir = s.ld_ir;
      ifb.select = 4'(s.sel);
    end

    mask = (1 << dw[cfg]) - 1;
    wr = '0;
    if (s.rst) begin
      for (int i = 0; i < 10; i++) nxt[i] = '0;
      m_ir[cfg] = '0;
    end else begin
      for (int i = 0; i < 10; i++) begin
        bit is_idx = (i >= 4) && (i < 4 + nidx[cfg]);
        bit ie = s.inc[i] && (i == 2 || i == 3 || is_idx);
        bit de = s.dec[i] && (i == 3 || is_idx);
        int v  = int'(m_reg[cfg][i]);
        nxt[i] = m_reg[cfg][i];
        if (s.we[i])                 nxt[i] = 16'(int'(s.c) & mask);
        else if (i == 1 && s.dr_read) nxt[i] = 16'(int'(s.ram) & mask);
        else if (ie && !de) begin
          wr[i]  = (v == mask);
          nxt[i] = 16'((v + 1) & mask);
        end else if (de && !ie) begin
          wr[i]  = (v == 0);
          nxt[i] = 16'((v + mask) & mask);
        end
      end
      if (s.ld_ir) m_ir[cfg] = m_reg[cfg][1] & 16'h003F;
    end
    for (int i = 0; i < 10; i++) m_reg[cfg][i] = nxt[i];

    e.cfg  = cfg;
    e.mux  = (s.sel < 10) ? nxt[s.sel] : 16'h0000;
    e.ac   = nxt[3];
    e.ir   = m_ir[cfg];
    e.wrap = wr;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  // Monitor: one expected record per clock edge, compared just after the edge.
  initial begin : monitor
    exp_t e;
    logic [15:0] am, aa, ai, aw;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.cfg == 0) begin
          am = ifa.mux_out; aa = ifa.ac_out;
          ai = {10'b0, ifa.ir_out}; aw = {6'b0, ifa.wrap};
        end else begin
          am = {8'b0, ifb.mux_out}; aa = {8'b0, ifb.ac_out};
          ai = {10'b0, ifb.ir_out}; aw = {6'b0, ifb.wrap};
        end
        check({e.tag, ".mux"},  am, e.mux);
        check({e.tag, ".ac"},   aa, e.ac);
        check({e.tag, ".ir"},   ai, e.ir);
        check({e.tag, ".wrap"}, aw, {6'b0, e.wrap});
      end
    end
  end

  initial begin : driver
    stim_t s;
    drive_idle();

    // ---------------- config A: 16-bit, 3 idx, 3 gp ----------------
    s = idle(0); s.rst = 1; step(0, s, "a_init_rst");
    s = idle(0); s.we = 10'h3FF; s.c = 16'hA5A5; step(0, s, "a_preload");
    s = idle(1); s.ld_ir = 1; step(0, s, "a_preload_ir");
    s = idle(2); s.inc = 10'h004; step(0, s, "a_pc_inc");
    s = idle(2); s.rst = 1; s.we = 10'h3FF; s.c = 16'h5555; s.ld_ir = 1; s.inc = 10'h3FF;
    step(0, s, "a_rst");
    for (int i = 0; i < 16; i++) step(0, idle(i), "a_rst_sel");

    s = idle(3); s.c = 16'h1234; s.we = 10'h218; step(0, s, "a_bcast");
    step(0, idle(4), "a_bcast_ra");
    step(0, idle(9), "a_bcast_gp_last");
    step(0, idle(5), "a_bcast_rb");

    s = idle(2); s.we = 10'h004; s.c = 16'hFFFF; step(0, s, "a_pc_load");
    s = idle(2); s.inc = 10'h004; step(0, s, "a_pc_wrap");
    step(0, idle(2), "a_pc_wrap_end");
    s = idle(4); s.we = 10'h010; s.c = 16'h0000; step(0, s, "a_ra_load");
    s = idle(4); s.dec = 10'h010; step(0, s, "a_ra_wrap");
    s = idle(4); s.inc = 10'h010; s.dec = 10'h010; step(0, s, "a_ra_incdec");
    s = idle(2); s.dec = 10'h004; step(0, s, "a_pc_dec_ignored");

    s = idle(3); s.we = 10'h008; s.c = 16'h0005; step(0, s, "a_ac5");
    s = idle(3); s.we = 10'h008; s.c = 16'h0100; s.inc = 10'h008; step(0, s, "a_we_over_inc");
    s = idle(3); s.we = 10'h008; s.c = 16'hFFFF; step(0, s, "a_ac_ones");
    s = idle(3); s.we = 10'h008; s.c = 16'h0100; s.inc = 10'h008; step(0, s, "a_we_no_wrap");

    s = idle(1); s.dr_read = 1; s.ram = 16'hBEEF; s.we = 10'h002; s.c = 16'h1111;
    step(0, s, "a_dr_prio");
    s = idle(1); s.we = 10'h002; s.c = 16'h00FF; step(0, s, "a_dr_ff");
    s = idle(1); s.ld_ir = 1; s.dr_read = 1; s.ram = 16'h0003; step(0, s, "a_ir_old_dr");
    s = idle(1); s.ld_ir = 1; step(0, s, "a_ir_new_dr");

    for (int n = 0; n < 400; n++) begin
      s = idle($urandom_range(0, 15));
      s.rst = ($urandom_range(0, 59) == 0);
      case ($urandom_range(0, 3))
        0: s.c = 16'h0000;
        1: s.c = 16'hFFFF;
        2: s.c = 16'h00FF;
        default: s.c = 16'($urandom);
      endcase
      s.ram = 16'($urandom);
      s.we  = 10'($urandom & $urandom & $urandom);
      s.inc = 10'($urandom & $urandom);
      s.dec = 10'($urandom & $urandom);
      s.dr_read = ($urandom_range(0, 3) == 0);
      s.ld_ir   = ($urandom_range(0, 3) == 0);
      step(0, s, "a_rand");
    end

    // ---------------- config B: 8-bit, 1 idx, 5 gp ----------------
    s = idle(0); s.rst = 1; step(1, s, "b_rst");
    s = idle(9); s.we = 10'h3FF; s.c = 16'h00C3; step(1, s, "b_fill");
    for (int i = 10; i < 16; i++) step(1, idle(i), "b_sel_oob");
    s = idle(2); s.we = 10'h004; s.c = 16'h00FF; step(1, s, "b_pc_ff");
    s = idle(2); s.inc = 10'h004; step(1, s, "b_pc_wrap");
    s = idle(7); s.inc = 10'h3E0; step(1, s, "b_gp_inc_ignored");
    s = idle(8); s.dec = 10'h3E0; step(1, s, "b_gp_dec_ignored");
    s = idle(5); s.inc = 10'h020; step(1, s, "b_reg5_not_idx");
    s = idle(4); s.we = 10'h010; s.c = 16'h00FF; step(1, s, "b_ra_ff");
    s = idle(4); s.inc = 10'h010; step(1, s, "b_ra_wrap");

    for (int n = 0; n < 400; n++) begin
      s = idle($urandom_range(0, 15));
      s.rst = ($urandom_range(0, 59) == 0);
      case ($urandom_range(0, 3))
        0: s.c = 16'h0000;
        1: s.c = 16'h00FF;
        2: s.c = 16'h00FE;
        default: s.c = 16'($urandom);
      endcase
      s.ram = 16'($urandom);
      s.we  = 10'($urandom & $urandom & $urandom);
      s.inc = 10'($urandom & $urandom);
      s.dec = 10'($urandom & $urandom);
      s.dr_read = ($urandom_range(0, 3) == 0);
      s.ld_ir   = ($urandom_range(0, 3) == 0);
      step(1, s, "b_rand");
    end

    @(negedge clk);
    drive_idle();
    repeat (2) @(posedge clk);
    #2;
    check("sb_drained", 16'(sb.size()), 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/param_register_file.md
# param_register_file

Parametrised successor to the processor's fixed 16-bit register unit. Holds AR, DR, PC, AC, a configurable bank of index registers with increment/decrement, and a configurable bank of plain general registers. Also holds the instruction register. It sits between the C bus (ALU result), data RAM and the control unit, and drives the B-bus read mux and AC to the ALU.

## Interface
Parameters:
- DATA_W, 16, register and bus width (≥ 8)
- NUM_IDX, 3, index registers with inc/dec (RA, RB, RC, ...) (≥ 1)
- NUM_GP, 3, plain general registers (R1, R2, ...) (≥ 1)
- OPC_W, 6, instruction register width (≤ DATA_W)
- Derived: NREG = 4 + NUM_IDX + NUM_GP; SEL_W = clog2(NREG)
- Register index map: 0 AR, 1 DR, 2 PC, 3 AC, 4..3+NUM_IDX index, 4+NUM_IDX..NREG-1 general

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- c_bus_in  in  DATA_W  write data from ALU/C bus
- we  in  NREG  one bit per register index, C-bus write enable
- inc  in  NREG  increment request; honoured for PC, AC, index regs only
- dec  in  NREG  decrement request; honoured for AC and index regs only
- ram_out  in  DATA_W  RAM read data
- dr_read  in  1  load DR from ram_out
- ld_ir  in  1  load IR from DR
- select  in  SEL_W  read-mux register index
- mux_out  out  DATA_W  selected register value (combinational from state)
- ac_out  out  DATA_W  AC value
- ir_out  out  OPC_W  IR value
- wrap  out  NREG  registered one-cycle pulse per register on inc/dec wrap

## Operation
- Per-register next-state priority, highest first: reset, we, dr_read (DR only), inc/dec, hold.
- we: the register loads c_bus_in. Several we bits may be set at once; every addressed register loads the same value.
- dr_read: DR loads ram_out when we[1] = 0. When we[1] = 1, the C-bus write wins and ram_out is dropped.
- inc/dec arithmetic is modulo 2^DATA_W.
  - inc: all-ones → 0 sets wrap[i].
  - dec: 0 → all-ones sets wrap[i].
- inc and dec both set on the same register: no change, no wrap.
- inc/dec on a register that does not support it (AR, DR, general regs; dec on PC): ignored, no wrap.
- we overriding inc/dec: inc/dec is discarded and wrap[i] stays 0.
- ld_ir: IR loads DR[OPC_W-1:0], using DR's value before the edge. A simultaneous DR write does not reach IR until the next ld_ir.
- mux_out = register[select]. When select ≥ NREG, mux_out = 0.
- No internal bypass: reads in the write cycle return the old value.

## Timing
- Reset (rst_n = 0 at an edge):
  - all registers, IR and wrap go to 0; mux_out and ac_out therefore read 0.
  - All other inputs are ignored that cycle.
- Reset asserted mid-sequence (e.g. during a PC increment run) clears state on that edge. No partial update survives.
- Write, dr_read, inc/dec and ld_ir latency: 1 cycle; the new value is visible on mux_out/ac_out/ir_out after the edge.
- wrap[i] is high for exactly the cycle following the wrapping edge, then 0 unless the register wraps again.
- mux_out is combinational in select; no setup beyond the normal clock path.
- No handshakes: control inputs are single-cycle, level-sampled at each edge.

## Test plan
- Reset: preload all regs with 0xA5A5, assert rst_n = 0 for one edge → every select reads 0x0000, ir_out = 0, wrap = 0.
- Broadcast write: c_bus_in = 0x1234 with we = bits {3, 4, NREG-1} → AC, RA and the last general reg read 0x1234; all others unchanged; ac_out = 0x1234 next cycle.
- Wrap both ways:
  - PC = 0xFFFF, inc[2] → PC = 0x0000, wrap[2] pulses one cycle.
  - RA = 0x0000, dec[4] → RA = 0xFFFF, wrap[4] pulses.
  - inc[4] and dec[4] together → RA holds, no pulse.
- Priority:
  - AC = 5, we[3] = 1 with c_bus_in = 0x0100 and inc[3] = 1 → AC = 0x0100, no wrap.
  - dr_read with ram_out = 0xBEEF and we[1] with c_bus_in = 0x1111 → DR = 0x1111.
- IR load: DR = 0x00FF, ld_ir with a same-cycle dr_read of ram_out = 0x0003 → ir_out = 0x3F (OPC_W = 6), DR = 0x0003; a following ld_ir → ir_out = 0x03.
- Parameter sweep: DATA_W = 8, NUM_IDX = 1, NUM_GP = 5 (NREG = 10, SEL_W = 4):
  - select = 10..15 → mux_out = 0.
  - Increment of 0xFF wraps to 0x00.
  - General regs ignore inc and dec.
